// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a per-slot guard interval.
// Optional leading-zero suppression is enabled by defining SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Load,
  input  logic [NUM_DIGITS-1:0]   Blank,
  output logic [6:0]              Seg,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [2:0]              Digit
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] hold_q, hold_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [2:0]              digit_q, digit_d;

  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] cur_sel;
  logic                  in_guard;
  logic                  suppress;
  logic                  dark;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0:    decode = 7'b0000001;
      4'h1:    decode = 7'b1001111;
      4'h2:    decode = 7'b0010010;
      4'h3:    decode = 7'b0000110;
      4'h4:    decode = 7'b1001100;
      4'h5:    decode = 7'b0100100;
      4'h6:    decode = 7'b0100000;
      4'h7:    decode = 7'b0001111;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0001100;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b1100000;
      4'hC:    decode = 7'b0110001;
      4'hD:    decode = 7'b1000010;
      4'hE:    decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  // Slot counter, scan index and hold register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d  = cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    hold_d = Load ? Value : hold_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Select the current digit's nibble, blank bit and anode without variable-width indexing.
  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    cur_sel   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_nib    = hold_q[4*i +: 4];
        cur_blank  = Blank[i];
        cur_sel[i] = 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  // lead_zero[k]: nibbles NUM_DIGITS-1 down to k are all zero; digit 0 never qualifies.
  always_comb begin
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (k == NUM_DIGITS - 1) lead_zero[k] = (hold_q[4*k +: 4] == 4'h0);
      else                     lead_zero[k] = lead_zero[k+1] && (hold_q[4*k +: 4] == 4'h0);
    end
    suppress = |(lead_zero & cur_sel);
  end
`else
  assign suppress = 1'b0;
`endif

  assign in_guard = (32'(cnt_q) < 32'(GUARD_CYCLES));
  assign dark     = in_guard || cur_blank || suppress;

  always_comb begin
    digit_d = idx_q;
    an_d    = '1;
    seg_d   = 7'b1111111;
    if (!dark) begin
      an_d  = ~cur_sel;
      seg_d = decode(cur_nib);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      hold_q  <= '0;
      seg_q   <= 7'b1111111;
      an_q    <= '1;
      digit_q <= 3'd0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      digit_q <= digit_d;
    end
  end

  assign Seg   = seg_q;
  assign AN    = an_q;
  assign Digit = digit_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: the driver pushes model expectations,
// an independent monitor pops and compares them against the registered outputs.
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int G  = 1;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          Load = 1'b0;
  logic [15:0]   Value = '0;
  logic [3:0]    Blank = '0;
  logic [6:0]    Seg;
  logic [3:0]    AN;
  logic [2:0]    Digit;

  seven_seg_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(G)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Value (Value),
    .Load  (Load),
    .Blank (Blank),
    .Seg   (Seg),
    .AN    (AN),
    .Digit (Digit)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] digit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_table [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: cycles since reset release plus the held value.
  int          m_n = 0;
  logic [15:0] m_hold = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  task automatic drive(input logic rstn, input logic load, input logic [15:0] value,
                       input logic [3:0] blank);
    exp_t e;
    int   cnt, idx;
    logic dark;
    @(negedge Clock);
    Resetn = rstn;
    Load   = load;
    Value  = value;
    Blank  = blank;
    if (!rstn) begin
      e      = '{seg: 7'b1111111, an: 4'b1111, digit: 3'd0};
      m_n    = 0;
      m_hold = '0;
    end else begin
      cnt  = m_n % RD;
      idx  = (m_n / RD) % N;
      dark = (cnt < G) || blank[idx];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (idx >= 1 && (m_hold >> (4 * idx)) == 16'h0) dark = 1'b1;
`endif
      e.digit = 3'(idx);
      if (dark) begin
        e.seg = 7'b1111111;
        e.an  = 4'b1111;
      end else begin
        e.seg = seg_table[(m_hold >> (4 * idx)) & 16'hF];
        e.an  = ~(4'b0001 << idx);
      end
      m_n++;
      if (load) m_hold = value;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int cycles, input logic [3:0] blank);
    for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 16'h0, blank);
  endtask

  // Monitor: compare each registered output against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seg",   32'(Seg),   32'(e.seg));
        check("an",    32'(AN),    32'(e.an));
        check("digit", 32'(Digit), 32'(e.digit));
        check("an_at_most_one_low", 32'($countones(~AN) <= 1), 32'd1);
      end
    end
  end

  initial begin
    logic [15:0] mask;
    int          bound;

    repeat (3) drive(1'b0, 1'b0, 16'h0, 4'h0);
    drive(1'b1, 1'b1, 16'h12AF, 4'h0);
    idle(20, 4'h0);

    idle(16, 4'b0100);
    bound = 0;
    while (!(((m_n / RD) % N) == 2 && (m_n % RD) == 2) && bound < 16) begin
      drive(1'b1, 1'b0, 16'h0, 4'b0100);
      bound++;
    end
    idle(8, 4'h0);

    bound = 0;
    while (((m_n / RD) % N) != 2 && bound < 16) begin
      drive(1'b1, 1'b0, 16'h0, 4'h0);
      bound++;
    end
    drive(1'b1, 1'b0, 16'h0, 4'h0);
    drive(1'b0, 1'b1, 16'h5555, 4'h0);
    idle(8, 4'h0);

    drive(1'b1, 1'b1, 16'h0050, 4'h0);
    idle(17, 4'h0);
    drive(1'b1, 1'b1, 16'h0000, 4'h0);
    idle(17, 4'h0);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h00FF;
        2:       mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 7) == 0),
            16'($urandom) & mask,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    bound = 0;
    while (exp_q.size() > 0 && bound < 10) begin
      @(posedge Clock);
      bound++;
    end
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for a multi-digit common-anode seven-segment display. It captures a packed hex value on a load strobe and cycles through the digits one at a time, each for a fixed number of clock cycles. For each digit it drives the shared active-low segment bus and that digit's active-low anode enable. A guard interval at the start of each digit slot suppresses ghosting. Successor to the single-digit combinational hex decoder; sits between datapath registers and board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal 1..8
REFRESH_DIV, 50000, clock cycles per digit slot; legal >= 2
GUARD_CYCLES, 1, cycles at start of each slot with everything dark; legal 0..REFRESH_DIV-1

Ports:
Clock  input  1  system clock, all state updates on rising edge
Resetn  input  1  synchronous active-low reset
Value  input  4*NUM_DIGITS  packed hex digits; digit i = Value[4i+3:4i], digit 0 rightmost
Load  input  1  capture Value into the hold register at this edge
Blank  input  NUM_DIGITS  per-digit force-dark, sampled live (not latched)
Seg  output  7  {A,B,C,D,E,F,G}, active-low, registered
AN  output  NUM_DIGITS  digit enables, active-low, registered, at most one low
Digit  output  3  index of the digit currently in its slot, registered

Behaviour:
- Synchronous, active-low reset (Resetn=0 at an edge) clears all state:
  - slot counter cnt=0, scan index idx=0, hold register=0;
  - Seg=7'b1111111, AN=all 1s, Digit=0.
- Reset mid-scan: the next edge returns every output to its reset value; scan restarts at digit 0, cnt=0.
- Slot counter: cnt counts 0..REFRESH_DIV-1.
  - At cnt==REFRESH_DIV-1: cnt goes to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
  - NUM_DIGITS=1: idx stays 0.
- Hold register:
  - Load=1 at an edge → hold <= Value.
  - Load=0 → hold retains its value.
  - Load coincident with a slot change: both take effect at the same edge.
- Output register, computed at every edge from the pre-edge cnt, idx, hold and Blank:
  - Digit <= idx.
  - If cnt < GUARD_CYCLES, or Blank[idx]=1, or the digit is suppressed (optional feature): AN <= all 1s, Seg <= 7'b1111111.
  - Otherwise: AN <= all 1s except bit idx = 0; Seg <= decode(hold nibble idx).
- Latency:
  - A slot change appears on AN/Seg one cycle after cnt wraps.
  - Loaded data appears on Seg no earlier than the second edge after Load.
- Decode table, nibble → {A..G}:
  - 0→0000001, 1→1001111, 2→0010010, 3→0000110
  - 4→1001100, 5→0100100, 6→0100000, 7→0001111
  - 8→0000000, 9→0001100, A→0001000, b→1100000
  - C→0110001, d→1000010, E→0110000, F→0111000
- Invariant: never more than one AN bit low in any cycle.
- Scan period is NUM_DIGITS*REFRESH_DIV cycles.

Optional Feature:
Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN
- Defined:
  - Digit k (k>=1) is suppressed when hold nibbles NUM_DIGITS-1 down to k are all zero.
  - Suppression uses the same dark output as Blank.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- Undefined:
  - No suppression; leading zeros are displayed.
  - The zero-detect logic is absent.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
- Reset: Resetn=0 for 3 cycles → Seg=1111111, AN=1111, Digit=0. Release → Digit walks 0,0,0,0,1,... advancing every 4 cycles.
- Load Value=16'h12AF, run 16 cycles; at the last cycle of each slot:
  - digit 0: AN=1110, Seg=0111000
  - digit 1: AN=1101, Seg=0001000
  - digit 2: AN=1011, Seg=0010010
  - digit 3: AN=0111, Seg=1001111
  - Then wraps to digit 0.
- Guard: cycle after each slot change → AN=1111, Seg=1111111. Bench checks at most one AN bit is low in every cycle.
- Blank=4'b0100 with hold 16'h12AF → digit-2 slot fully dark; other digits unchanged. Deassert Blank mid-slot → digit 2 lights the next cycle.
- Reset asserted during digit-2 slot, with Load=1 and Value=16'h5555 at the same edge → reset wins: hold=0, outputs dark, next slot is digit 0 showing 0000001.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN defined:
  - Load 16'h0050 → digits 3 and 2 dark; digit 1 Seg=0100100; digit 0 Seg=0000001.
  - Load 16'h0000 → only digit 0 lit, showing 0000001.
  - Without the macro, 16'h0050 lights all four digits.
